// File: rtl/au_pkg.sv
// Shared constants, FSM state type and width helpers for the au_reduce frame reducer.
package au_pkg;

    localparam logic [1:0] AU_ABS_SUM = 2'b00;
    localparam logic [1:0] AU_MAX     = 2'b01;
    localparam logic [1:0] AU_MIN     = 2'b10;
    localparam logic [1:0] AU_RANGE   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ACC  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Result must hold LEN * 2^(W-1) as a positive signed value.
    function automatic int acc_width(input int w, input int len);
        return w + $clog2(len) + 1;
    endfunction

    function automatic int idx_width(input int len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

endpackage

// File: rtl/au_cmp.sv
// Combinational sample compare: running max/min update, magnitude and strict-improvement flags.
module au_cmp #(
    parameter int W = 16
) (
    input  logic signed [W-1:0] mx,
    input  logic signed [W-1:0] mn,
    input  logic signed [W-1:0] sample,
    output logic signed [W-1:0] new_max,
    output logic signed [W-1:0] new_min,
    output logic        [W:0]   mag,
    output logic                gt,
    output logic                lt
);

    logic signed [W:0] wide;

    // One extra bit so that |-2^(W-1)| is representable.
    always_comb begin
        wide    = (W+1)'(sample);
        gt      = sample > mx;
        lt      = sample < mn;
        new_max = gt ? sample : mx;
        new_min = lt ? sample : mn;
        mag     = (wide < 0) ? $unsigned(-wide) : $unsigned(wide);
    end

endmodule

// File: rtl/au_reduce.sv
// Frame reducer (abs-sum / max / min / range) over LEN samples with valid/ready handshakes.
// Define AU_REDUCE_IDX_EN to add out_idx, the position of the first extremum.
module au_reduce
    import au_pkg::*;
#(
    parameter  int W    = 16,
    parameter  int LEN  = 8,
    localparam int ACCW = acc_width(W, LEN),
    localparam int CW   = idx_width(LEN)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [1:0]             mode,
    input  logic signed [W-1:0]    in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic signed [ACCW-1:0] out_data,
`ifdef AU_REDUCE_IDX_EN
    output logic [CW-1:0]          out_idx,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy
);

    state_t                 state, next;
    logic [1:0]             mode_r;
    logic [CW-1:0]          cnt;
    logic signed [ACCW-1:0] acc, res;
    logic signed [W-1:0]    mx, mn, new_max, new_min;
    logic signed [W:0]      rng;
    logic [W:0]             mag;
    logic                   gt, lt, hs, last;

    au_cmp #(.W(W)) u_cmp (
        .mx      (mx),
        .mn      (mn),
        .sample  (in_data),
        .new_max (new_max),
        .new_min (new_min),
        .mag     (mag),
        .gt      (gt),
        .lt      (lt)
    );

    function automatic logic signed [ACCW-1:0] sext(input logic signed [W:0] v);
        return ACCW'(v);
    endfunction

    assign hs   = in_valid && (state == ACC);
    assign last = hs && (cnt == CW'(LEN - 1));
    assign rng  = (W+1)'(new_max) - (W+1)'(new_min);

    // Final result includes the sample being accepted on the last handshake.
    always_comb begin
        res = '0;
        case (mode_r)
            AU_ABS_SUM: res = acc + $signed({{(ACCW-W-1){1'b0}}, mag});
            AU_MAX:     res = sext((W+1)'(new_max));
            AU_MIN:     res = sext((W+1)'(new_min));
            default:    res = sext(rng);
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

    always_comb begin
        next      = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: if (start) next = ACC;
            ACC: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (last) next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) next = IDLE;
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_r   <= AU_ABS_SUM;
            cnt      <= '0;
            acc      <= '0;
            mx       <= '0;
            mn       <= '0;
            out_data <= '0;
        end else if (state == IDLE && start) begin
            mode_r <= mode;
            cnt    <= '0;
            acc    <= '0;
            mx     <= {1'b1, {(W-1){1'b0}}};
            mn     <= {1'b0, {(W-1){1'b1}}};
        end else if (hs) begin
            if (mode_r == AU_ABS_SUM) acc <= res;
            if ((mode_r == AU_MAX || mode_r == AU_RANGE) && gt) mx <= new_max;
            if ((mode_r == AU_MIN || mode_r == AU_RANGE) && lt) mn <= new_min;
            cnt <= cnt + CW'(1);
            if (last) out_data <= res;
        end
    end

`ifdef AU_REDUCE_IDX_EN
    logic [CW-1:0] imx, imn;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imx     <= '0;
            imn     <= '0;
            out_idx <= '0;
        end else if (state == IDLE && start) begin
            imx <= '0;
            imn <= '0;
        end else if (hs) begin
            if (gt) imx <= cnt;
            if (lt) imn <= cnt;
            if (last) begin
                case (mode_r)
                    AU_MAX:  out_idx <= gt ? cnt : imx;
                    AU_MIN:  out_idx <= lt ? cnt : imn;
                    default: out_idx <= '0;
                endcase
            end
        end
    end
`endif

endmodule

// File: doc/au_reduce.md
Name: au_reduce

Overview:
- Parametrised, sequential successor of the single-cycle abs/max/min arithmetic unit in the SRA datapath.
- Reduces a frame of LEN signed samples to one result under a selected mode:
  - sum of absolute values
  - running max
  - running min
  - range (max - min), a new mode
- Samples enter and the result leaves over valid/ready handshakes.
- Sits between the sample shift-register array and the downstream sorter/decision logic.

Parameters:
- W, 16, sample width (signed two's complement), W >= 2.
- LEN, 8, samples per frame, LEN >= 2.
- ACCW, W+$clog2(LEN)+1, result width. Derived; do not override.

Ports:
- clk  in  1  rising-edge clock, single clock domain.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begins a frame; sampled only in IDLE.
- mode  in  2  operation select: 00 abs-sum, 01 max, 10 min, 11 range. Latched on the accepted start.
- in_data  in  W  signed sample.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepts a sample.
- out_data  out  ACCW  signed result, sign-extended.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- busy  out  1  high in ACC and DONE.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, all outputs 0, counter 0, accumulators 0, mode_r 0.
- States: IDLE, ACC, DONE. All outputs are registered or decoded from state only; there is no combinational input-to-output path.
- IDLE:
  - in_ready=0, out_valid=0, busy=0.
  - start=1: mode_r<=mode, cnt<=0, acc<=0, mx<=-2^(W-1), mn<=2^(W-1)-1, then go to ACC.
- ACC:
  - in_ready=1, busy=1.
  - On in_valid&in_ready, per mode_r:
    - 00: acc<=acc+|in_data|. |-2^(W-1)| = 2^(W-1), exact at ACCW bits.
    - 01: mx<=max(mx,in_data).
    - 10: mn<=min(mn,in_data).
    - 11: update mx and mn.
  - Then cnt++.
  - On the handshake with cnt==LEN-1: go to DONE, and out_data is loaded with the final result in the same edge.
  - The range result is mx-mn computed on the values including the last sample. It is always >= 0 and fits in W+1 bits.
  - in_valid gaps are allowed; cnt advances only on handshakes.
- Latency: out_valid=1 the cycle after the last accepted sample.
- DONE:
  - out_valid=1, in_ready=0, busy=1.
  - out_data is held stable until out_valid&out_ready, then go to IDLE (out_valid=0 next cycle).
- start is ignored in ACC and DONE. mode changes after start have no effect until the next frame.
- Ties in max/min keep the earlier sample.
- Reset mid-frame aborts the frame. No partial result is emitted; the next frame is computed from clean initial values.
- Back-to-back frames: start may be high in the IDLE cycle right after the DONE handshake, giving one idle cycle between frames.

Optional Feature:
- Macro: AU_REDUCE_IDX_EN.
- Defined:
  - Adds output out_idx (out, $clog2(LEN) bits): position (0..LEN-1) of the first extremum for modes 01/10; 0 for modes 00/11.
  - Reset value 0; valid and held alongside out_data.
  - Internal index registers update only on a strict improvement.
- Undefined: the port and its registers are absent; all other behaviour is identical.

Decomposition:
- Package au_pkg:
  - mode constants AU_ABS_SUM=2'b00, AU_MAX=2'b01, AU_MIN=2'b10, AU_RANGE=2'b11
  - state enum IDLE/ACC/DONE
  - widths derived from W/LEN
- Sub-module au_cmp (combinational, parameter W):
  - inputs: current mx/mn and sample
  - outputs: new max, new min, |sample|, and improvement flags
  - au_reduce holds the FSM, counter and registers.

Test Plan (W=16, LEN=4):
- Abs-sum: mode=00, samples -3,5,-32768,7 -> out_data=32783, out_valid one cycle after the 4th handshake.
- Max: mode=01, samples 10,-20,30,30 -> out_data=30; with AU_REDUCE_IDX_EN, out_idx=2.
- Min: mode=10, samples 0,-1,-1,5 -> out_data=-1 (sign-extended to all ones); out_idx=1. Also: 32767 x4 -> 32767.
- Range: mode=11, samples 100,-100,50,0 -> out_data=200. Also: -32768,32767,0,0 -> 65535.
- Flow control:
  - Input side: in_valid toggled 1,0,0,1 with 2-cycle gaps -> only 4 handshakes are counted.
  - Output side: out_ready held low 5 cycles -> out_data/out_valid stable, in_ready=0, start pulses ignored; the handshake returns the block to IDLE.
- Reset: rst asserted after 2 samples of a max frame -> all outputs 0 immediately. A following frame 1,2,3,4 -> 4, unaffected by prior samples.
